// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style echo responder for FPGA loopback: accepts a trigger pulse, waits a burst delay, then emits
// an echo whose width encodes a programmed distance. Define ULTRA_JITTER_EN to add LFSR width jitter.
module ultrasonic_echo_responder #(
  parameter int unsigned TRIG_MIN_CYC = 500,
  parameter int unsigned BURST_CYC    = 10000,
  parameter int unsigned MAX_ECHO_CYC = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 500000,
  parameter int unsigned JIT_BITS     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [31:0] echo_width,
  output logic        echo,
  output logic        busy,
  output logic        trig_short,
  output logic [15:0] meas_cnt
);

  typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;

  localparam logic [31:0] TRIG_MIN  = 32'(TRIG_MIN_CYC);
  localparam logic [31:0] BURST_END = 32'(BURST_CYC);
  localparam logic [31:0] MAX_W     = 32'(MAX_ECHO_CYC);
  localparam logic [31:0] HOLD_END  = 32'(HOLDOFF_CYC - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] w_reg;
  logic [31:0] w_clamp;
  logic [31:0] w_next;
  logic        trig_m, trig_s;
  logic        accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
    end else begin
      trig_m <= trigger;
      trig_s <= trig_m;
    end
  end

  assign accept = (state == TRIG) && !trig_s && (cnt >= TRIG_MIN);

`ifdef ULTRA_JITTER_EN
  logic [15:0] lfsr, lfsr_nxt;
  logic [32:0] w_sum;

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lfsr <= 16'hACE1;
    else if (accept) lfsr <= lfsr_nxt;
  end

  // Jitter comes from the value the LFSR steps to on this acceptance.
  always_comb begin
    w_clamp = (echo_width == 32'd0 || echo_width > MAX_W) ? MAX_W : echo_width;
    w_sum   = {1'b0, w_clamp} + 33'(lfsr_nxt[JIT_BITS-1:0]);
    w_next  = (w_sum > {1'b0, MAX_W}) ? MAX_W : w_sum[31:0];
  end
`else
  always_comb begin
    w_clamp = (echo_width == 32'd0 || echo_width > MAX_W) ? MAX_W : echo_width;
    w_next  = w_clamp;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      w_reg      <= '0;
      echo       <= 1'b0;
      trig_short <= 1'b0;
      meas_cnt   <= '0;
    end else begin
      trig_short <= 1'b0;
      case (state)
        IDLE: if (trig_s) begin
          state <= TRIG;
          cnt   <= '0;
        end
        TRIG: begin
          if (!trig_s) begin
            cnt <= '0;
            if (accept) begin
              state <= BURST;
              w_reg <= w_next;
            end else begin
              state      <= IDLE;
              trig_short <= 1'b1;
            end
          end else if (cnt < TRIG_MIN) begin
            cnt <= cnt + 32'd1;
          end
        end
        BURST: if (cnt == BURST_END) begin
          state <= ECHO;
          cnt   <= '0;
          echo  <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
        // w_reg is never zero, so the echo is high for exactly w_reg cycles.
        ECHO: if (cnt == w_reg - 32'd1) begin
          state    <= HOLDOFF;
          cnt      <= '0;
          echo     <= 1'b0;
          meas_cnt <= meas_cnt + 16'd1;
        end else begin
          cnt <= cnt + 32'd1;
        end
        HOLDOFF: if (cnt == HOLD_END) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 32'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          echo  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == BURST) || (state == ECHO) || (state == HOLDOFF);

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomized bench for ultrasonic_echo_responder against a pulse-level model of trigger/echo behaviour.
module tb_ultrasonic_echo_responder;
  localparam int TRIG_MIN = 10;
  localparam int BURST    = 20;
  localparam int MAXW     = 1000;
  localparam int HOLD     = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] echo_width = '0;
  logic        echo, busy, trig_short;
  logic [15:0] meas_cnt;

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC(TRIG_MIN), .BURST_CYC(BURST), .MAX_ECHO_CYC(MAXW),
    .HOLDOFF_CYC(HOLD), .JIT_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .echo_width(echo_width),
    .echo(echo), .busy(busy), .trig_short(trig_short), .meas_cnt(meas_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: records echo edges and trig_short pulses with posedge timestamps.
  int   cyc = 0;
  int   n_rise = 0, n_fall = 0, rise_cyc = 0, last_w = 0, n_short = 0, short_cyc = 0;
  logic prev_echo = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_echo <= echo;
    if (echo && !prev_echo) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (!echo && prev_echo) begin
      n_fall <= n_fall + 1;
      last_w <= cyc - rise_cyc;
    end
    if (trig_short) begin
      n_short   <= n_short + 1;
      short_cyc <= cyc;
    end
  end

  int          exp_meas = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  // Expected echo width for an accepted trigger; steps the jitter model when enabled.
  task automatic model_accept(input int w, output int wexp);
    wexp = (w == 0 || w > MAXW) ? MAXW : w;
`ifdef ULTRA_JITTER_EN
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    wexp   = wexp + int'(m_lfsr[3:0]);
    if (wexp > MAXW) wexp = MAXW;
`endif
  endtask

  // fall_edge = index of the first posedge that samples the pad low.
  task automatic send(input int h, input int w, output int fall_edge);
    @(negedge clk);
    trigger    = 1'b1;
    echo_width = w;
    repeat (h) @(negedge clk);
    trigger   = 1'b0;
    fall_edge = cyc + 1;
  endtask

  task automatic wait_rise(input int r0);
    int t = 0;
    while (n_rise == r0 && t < BURST + 60) begin @(negedge clk); t++; end
    chk("echo_rise_seen", n_rise - r0, 1);
  endtask

  task automatic wait_fall(input int f0);
    int t = 0;
    while (n_fall == f0 && t < MAXW + 100) begin @(negedge clk); t++; end
    chk("echo_fall_seen", n_fall - f0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < HOLD + 10) begin @(negedge clk); t++; end
    chk(tag, longint'(!busy && t >= HOLD - 3 && t <= HOLD + 3), 1);
  endtask

  task automatic run_valid(input int h, input int w);
    int r0, f0, fe, wexp;
    r0 = n_rise;
    f0 = n_fall;
    send(h, w, fe);
    model_accept(w, wexp);
    repeat (5) @(negedge clk);
    echo_width = $urandom;
    wait_rise(r0);
    chk("echo_latency", rise_cyc - fe, BURST + 3);
    wait_fall(f0);
    chk("echo_width", last_w, wexp);
    exp_meas = (exp_meas + 1) & 16'hFFFF;
    @(negedge clk);
    chk("meas_cnt", meas_cnt, exp_meas);
    chk("busy_in_holdoff", busy, 1);
    wait_idle("holdoff_release");
    repeat (3) @(negedge clk);
  endtask

  task automatic run_short(input int h);
    int s0, r0, fe;
    logic bad;
    s0  = n_short;
    r0  = n_rise;
    bad = 1'b0;
    send(h, $urandom_range(1, 500), fe);
    repeat (30) begin
      @(negedge clk);
      if (echo || busy) bad = 1'b1;
    end
    chk("short_pulse_count", n_short - s0, 1);
    chk("short_timing", longint'(short_cyc - fe >= 1 && short_cyc - fe <= 4), 1);
    chk("short_no_activity", bad, 0);
    chk("short_no_echo", n_rise - r0, 0);
    chk("short_meas_cnt", meas_cnt, exp_meas);
  endtask

  initial begin
    int r0, f0, fe, wexp, h, sel, w;
    repeat (3) @(negedge clk);
    chk("reset_echo", echo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_trig_short", trig_short, 0);
    chk("reset_meas_cnt", meas_cnt, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_valid(12, 100);
    run_short(5);
    run_valid(12, 0);
    run_valid(12, 5000);
    run_valid(11, MAXW);

    // Triggers during ECHO and HOLDOFF must be ignored.
    r0 = n_rise;
    f0 = n_fall;
    send(12, 100, fe);
    model_accept(100, wexp);
    wait_rise(r0);
    repeat (10) @(negedge clk);
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    wait_fall(f0);
    chk("ignored_width", last_w, wexp);
    exp_meas = (exp_meas + 1) & 16'hFFFF;
    repeat (5) @(negedge clk);
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    chk("busy_during_holdoff", busy, 1);
    repeat (HOLD + 60) @(negedge clk);
    chk("ignored_one_echo", n_rise - r0, 1);
    chk("ignored_busy_low", busy, 0);
    chk("ignored_meas_cnt", meas_cnt, exp_meas);

    // Asynchronous reset in the middle of an echo.
    r0 = n_rise;
    send(12, 300, fe);
    model_accept(300, wexp);
    wait_rise(r0);
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset_echo", echo, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_meas_cnt", meas_cnt, 0);
    exp_meas = 0;
    m_lfsr   = 16'hACE1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_valid(12, 100);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_short($urandom_range(3, 8));
      end else begin
        h   = $urandom_range(12, 20);
        sel = $urandom_range(0, 4);
        case (sel)
          0:       w = 0;
          1:       w = $urandom_range(1, 200);
          2:       w = MAXW;
          3:       w = $urandom_range(MAXW + 1, 5000);
          default: w = MAXW - 1;
        endcase
        run_valid(h, w);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
